rbus_uart_rx_core: RTL and testbench

//  UART 8N1 receiver with byte FIFO; upstream stage of the rbus UART RX packet former.

---
 rtl/rbus_uart_pkg.sv | 23 ++
 rtl/rbus_uart_rx_fifo.sv | 58 +++++
 rtl/rbus_uart_rx_core.sv | 141 ++++++++++++++
 tb/tb_rbus_uart_rx_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rbus_uart_pkg.sv
// Shared definitions for the rbus UART cores: receive FSM encoding and bit-timing defaults.
package rbus_uart_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4
  } uart_state_e;

  localparam int unsigned CLK_DIV_DEFAULT = 868;

  // Timer reload that lands the first sample in the middle of the start bit.
  function automatic logic [15:0] half_bit_load(input int unsigned div);
    return 16'(div / 2 - 1);
  endfunction

  function automatic logic [15:0] full_bit_load(input int unsigned div);
    return 16'(div - 1);
  endfunction

endpackage

// File: rtl/rbus_uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head byte is always visible on dout.
module rbus_uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               rd_en_s;
  logic               wr_en_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));
  assign dout  = mem_r[rd_ptr_r];

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
  assign rd_en_s = pop && !empty;
  assign wr_en_s = push && (!full || rd_en_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= FIFO_AW'(0);
      rd_ptr_r <= FIFO_AW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rbus_uart_rx_core.sv
// UART 8N1 receiver: synchroniser, bit timer, deframing FSM and byte FIFO with
// a strobe/ack consumer interface plus overrun and framing-error pulses.
module rbus_uart_rx_core
  import rbus_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       o_stb,
  output logic [7:0] o_data,
  input  logic       i_ack,
  output logic       o_ovr,
  output logic       o_ferr
);

  localparam logic [15:0] HALF_LOAD = half_bit_load(CLK_DIV);
  localparam logic [15:0] FULL_LOAD = full_bit_load(CLK_DIV);

  logic [1:0]  sync_r;
  logic        rxd_s;
  uart_state_e state_r;
  logic [15:0] timer_r;
  logic        tick_s;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shreg_r;
  logic        ferr_r;
  logic        ovr_r;
  logic        push_s;
  logic        pop_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;

  assign rxd_s  = sync_r[1];
  assign tick_s = (timer_r == 16'd0);
  assign push_s = (state_r == ST_STOP) && tick_s && rxd_s;
  assign pop_s  = i_ack && !fifo_empty_s;
  assign o_stb  = !fifo_empty_s;
  assign o_ovr  = ovr_r;
  assign o_ferr = ferr_r;

  // Two-flop synchroniser for the asynchronous line, idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  // Deframing FSM with bit timer, shift register and framing-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_WAIT_HIGH;
      timer_r   <= 16'd0;
      bit_cnt_r <= 3'd0;
      shreg_r   <= 8'h00;
      ferr_r    <= 1'b0;
    end else begin
      ferr_r <= 1'b0;
      case (state_r)
        ST_WAIT_HIGH: begin
          if (rxd_s) state_r <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!rxd_s) begin
            state_r <= ST_START;
            timer_r <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (!rxd_s) begin
              state_r   <= ST_DATA;
              timer_r   <= FULL_LOAD;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shreg_r <= {rxd_s, shreg_r[7:1]};
            timer_r <= FULL_LOAD;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (rxd_s) begin
              state_r <= ST_IDLE;
            end else begin
              // A low stop bit may be a break; wait for the line to recover first.
              ferr_r  <= 1'b1;
              state_r <= ST_WAIT_HIGH;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_WAIT_HIGH;
        end
      endcase
    end
  end

  // Overrun pulse: completed byte found the FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r <= 1'b0;
    end else begin
      ovr_r <= push_s && fifo_full_s && !pop_s;
    end
  end

  rbus_uart_rx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (shreg_r),
    .pop   (pop_s),
    .dout  (o_data),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

endmodule

// File: tb/tb_rbus_uart_rx_core.sv
// Directed bench for rbus_uart_rx_core: frame table plus glitch, break,
// overrun, full-with-pop and mid-frame reset sequences.
module tb_rbus_uart_rx_core;
  import rbus_uart_pkg::*;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rxd   = 1'b1;
  logic       i_ack = 1'b0;
  logic       o_stb;
  logic [7:0] o_data;
  logic       o_ovr;
  logic       o_ferr;

  int checks   = 0;
  int errors   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    logic       exp_stb;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  rbus_uart_rx_core #(
    .CLK_DIV (16),
    .FIFO_AW (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .o_stb  (o_stb),
    .o_data (o_data),
    .i_ack  (i_ack),
    .o_ovr  (o_ovr),
    .o_ferr (o_ferr)
  );

  always @(negedge clk) begin
    if (o_ferr) ferr_cnt++;
    if (o_ovr) ovr_cnt++;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 16 clocks per bit; ack_at picks the loop index where i_ack is held for one cycle.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int ack_at,
                            input logic tail);
    int bi;
    for (int n = 0; n < 160; n++) begin
      @(negedge clk);
      if (n < 16) begin
        rxd = 1'b0;
      end else if (n < 144) begin
        bi  = (n - 16) / 16;
        rxd = d[bi[2:0]];
      end else begin
        rxd = stopb;
      end
      i_ack = (n == ack_at);
    end
    @(negedge clk);
    rxd   = tail;
    i_ack = 1'b0;
    idle(8);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] e);
    check1({name, "_stb"}, o_stb, 1'b1);
    check8(name, o_data, e);
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
  endtask

  initial begin
    int f0;
    int o0;
    int bi;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    vecs[5] = '{8'h6E, 1'b1, 1'b1, 8'h6E, 0};

    idle(4);
    check1("rst_stb", o_stb, 1'b0);
    check8("rst_data", o_data, 8'h00);
    check1("rst_ovr", o_ovr, 1'b0);
    check1("rst_ferr", o_ferr, 1'b0);
    rst = 1'b0;
    idle(10);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].d, vecs[i].stopb, -1, 1'b1);
      check1("vec_stb", o_stb, vecs[i].exp_stb);
      check_int("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_stb) begin
        check8("vec_data", o_data, vecs[i].exp_data);
        idle(20);
        check1("vec_hold", o_stb, 1'b1);
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        check1("vec_popped", o_stb, 1'b0);
      end
      idle(4);
    end

    // Short low glitch on an idle line.
    f0 = ferr_cnt;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(30);
    check1("glitch_stb", o_stb, 1'b0);
    check_int("glitch_ferr", ferr_cnt - f0, 0);
    check_int("glitch_state", int'(dut.state_r), int'(ST_IDLE));

    // Framing error followed by a held-low line, then recovery.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    idle(200);
    check_int("brk_ferr", ferr_cnt - f0, 1);
    check1("brk_stb", o_stb, 1'b0);
    rxd = 1'b1;
    idle(20);
    send_frame(8'h11, 1'b1, -1, 1'b1);
    pop_expect("after_brk", 8'h11);
    check1("after_brk_empty", o_stb, 1'b0);

    // Overrun on the 17th byte.
    o0 = ovr_cnt;
    for (int b = 0; b < 16; b++) send_frame(8'(b), 1'b1, -1, 1'b1);
    check_int("fill16_ovr", ovr_cnt - o0, 0);
    send_frame(8'h10, 1'b1, -1, 1'b1);
    check_int("ovr_cnt", ovr_cnt - o0, 1);
    for (int b = 0; b < 16; b++) pop_expect("ovr_pop", 8'(b));
    check1("ovr_drained", o_stb, 1'b0);

    // Full FIFO, stop-bit tick coincides with a pop.
    o0 = ovr_cnt;
    for (int b = 0; b < 16; b++) send_frame(8'(8'h20 + b), 1'b1, -1, 1'b1);
    send_frame(8'h30, 1'b1, 154, 1'b1);
    check_int("coinc_ovr", ovr_cnt - o0, 0);
    for (int b = 1; b < 17; b++) pop_expect("coinc_pop", 8'(8'h20 + b));
    check1("coinc_drained", o_stb, 1'b0);

    // Reset in the middle of a data bit with three bytes queued.
    send_frame(8'h61, 1'b1, -1, 1'b1);
    send_frame(8'h62, 1'b1, -1, 1'b1);
    send_frame(8'h63, 1'b1, -1, 1'b1);
    check1("pre_rst_stb", o_stb, 1'b1);
    f0 = ferr_cnt;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n < 16) begin
        rxd = 1'b0;
      end else begin
        bi  = (n - 16) / 16;
        rxd = bi[0];
      end
    end
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    check1("midrst_stb", o_stb, 1'b0);
    check8("midrst_data", o_data, 8'h00);
    rst = 1'b0;
    idle(200);
    check1("midrst_nobyte", o_stb, 1'b0);
    check_int("midrst_ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1, -1, 1'b1);
    pop_expect("post_rst", 8'h5A);
    check1("post_rst_empty", o_stb, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
